// File: rtl/led_pattern_gen_pkg.sv
// Shared mode encoding and prescaler sizing helpers for the LED pattern generator.
package led_pattern_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BINARY  = 2'd0;
  localparam mode_t MODE_WALK    = 2'd1;
  localparam mode_t MODE_BOUNCE  = 2'd2;
  localparam mode_t MODE_BREATHE = 2'd3;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_cnt_w(input int div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the board-level controller and the LED pattern generator.
interface led_pattern_gen_if
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS = 6
);
  logic                enable;
  mode_t               mode_in;
  logic                mode_load;
  mode_t               mode_active;
  logic                tick;
  logic [NUM_LEDS-1:0] leds;
  logic                blink;

  modport master (
    output enable, mode_in, mode_load,
    input  mode_active, tick, leds, blink
  );

  modport slave (
    input  enable, mode_in, mode_load,
    output mode_active, tick, leds, blink
  );
endinterface

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Exact integer divider: one-cycle tick every DIV enabled cycles, frozen while enable is low.
module tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk50,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int              CNT_W = calc_cnt_w(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk50) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Gated by enable so a paused count parked at LAST cannot step the pattern.
  assign tick = enable && !rst && (cnt == LAST);
endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: binary/walk/bounce/breathe stepped at TICK_HZ, heartbeat on wrap.
// Outputs are registered from next-state so leds/blink show a step the cycle after its tick.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 8,
  parameter int NUM_LEDS = 6,
  parameter int PWM_BITS = 8
) (
  input logic             clk50,
  input logic             rst,
  led_pattern_gen_if.slave bus
);
  localparam int                  DIV      = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
  localparam logic [NUM_LEDS-1:0] PAT_ONE  = NUM_LEDS'(1);

  logic tick;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk50  (clk50),
    .rst    (rst),
    .enable (bus.enable),
    .tick   (tick)
  );

  mode_t               mode_q, pend_mode_q, mode_d, load_mode;
  logic                pend_q, dir_up_q, dir_up_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d, leds_q, leds_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, pwm_q, pwm_d;
  logic                blink_q, wrap, restart;

  always_comb begin
    mode_d    = mode_q;
    pat_d     = pat_q;
    dir_up_d  = dir_up_q;
    duty_d    = duty_q;
    wrap      = 1'b0;
    load_mode = bus.mode_load ? bus.mode_in : pend_mode_q;
    restart   = tick && (bus.mode_load || pend_q);
    pwm_d     = bus.enable ? pwm_q + 1'b1 : pwm_q;

    if (restart) begin
      mode_d   = load_mode;
      pat_d    = (load_mode == MODE_WALK || load_mode == MODE_BOUNCE) ? PAT_ONE : '0;
      dir_up_d = 1'b1;
      duty_d   = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_BINARY: begin
          pat_d = pat_q + 1'b1;
          wrap  = &pat_q;
        end
        MODE_WALK: begin
          pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
          wrap  = pat_q[NUM_LEDS-1];
        end
        MODE_BOUNCE: begin
          if (dir_up_q) begin
            pat_d    = pat_q << 1;
            dir_up_d = !pat_q[NUM_LEDS-2];
          end else begin
            pat_d    = pat_q >> 1;
            wrap     = pat_q[1];
            dir_up_d = pat_q[1];
          end
        end
        default: begin
          // Breathe: endpoints 0 and DUTY_MAX are each held for a single tick.
          if (dir_up_q) begin
            duty_d   = duty_q + 1'b1;
            dir_up_d = (duty_q != DUTY_MAX - DUTY_ONE);
          end else begin
            duty_d   = duty_q - 1'b1;
            wrap     = (duty_q == DUTY_ONE);
            dir_up_d = (duty_q == DUTY_ONE);
          end
        end
      endcase
    end

    leds_d = (mode_d == MODE_BREATHE) ? {NUM_LEDS{pwm_d < duty_d}} : pat_d;
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      mode_q      <= MODE_BINARY;
      pend_mode_q <= MODE_BINARY;
      pend_q      <= 1'b0;
      pat_q       <= '0;
      dir_up_q    <= 1'b1;
      duty_q      <= '0;
      pwm_q       <= '0;
      leds_q      <= '0;
      blink_q     <= 1'b0;
    end else begin
      if (bus.mode_load) begin
        pend_mode_q <= bus.mode_in;
        pend_q      <= 1'b1;
      end
      if (restart) begin
        pend_q <= 1'b0;
      end
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      dir_up_q <= dir_up_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      leds_q   <= leds_d;
      blink_q  <= blink_q ^ wrap;
    end
  end

  assign bus.tick        = tick;
  assign bus.mode_active = mode_q;
  assign bus.leds        = leds_q;
  assign bus.blink       = blink_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with DIV=10, four LEDs and 3-bit PWM.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  logic clk50 = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic exp_blink = 1'b0;

  always #5 clk50 = ~clk50;

  led_pattern_gen_if #(.NUM_LEDS(4)) bus ();

  led_pattern_gen #(
    .CLK_HZ   (40),
    .TICK_HZ  (4),
    .NUM_LEDS (4),
    .PWM_BITS (3)
  ) dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk50);
    @(negedge clk50);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (bus.tick !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (bus.tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_tick: no tick after %0d cycles, wanted one", n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.mode_in = MODE_BINARY;
    bus.mode_load = 1'b0;
    @(negedge clk50);
    repeat (3) step();
    total++; if (bus.leds !== 4'h0) begin bad++; $display("FAIL reset_leds: got %h want 0", bus.leds); end
    total++; if (bus.blink !== 1'b0) begin bad++; $display("FAIL reset_blink: got %b want 0", bus.blink); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
    total++; if (bus.mode_active !== MODE_BINARY) begin bad++; $display("FAIL reset_mode: got %0d want 0", bus.mode_active); end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      total++; if (bus.tick !== 1'(c == 10)) begin bad++; $display("FAIL first_tick cycle %0d: got %b want %b", c, bus.tick, c == 10); end
      total++; if (bus.leds !== 4'h0 || bus.blink !== 1'b0) begin bad++; $display("FAIL pre_tick_out cycle %0d: got leds=%h blink=%b want 0/0", c, bus.leds, bus.blink); end
      if (c < 10) step();
    end
  endtask

  task automatic test_binary();
    int n;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) exp_blink = ~exp_blink;
      total++; if (bus.leds !== 4'(i)) begin bad++; $display("FAIL binary_leds tick %0d: got %h want %h", i, bus.leds, 4'(i)); end
      total++; if (bus.blink !== exp_blink) begin bad++; $display("FAIL binary_blink tick %0d: got %b want %b", i, bus.blink, exp_blink); end
      total++; if (bus.mode_active !== MODE_BINARY) begin bad++; $display("FAIL binary_mode tick %0d: got %0d want 0", i, bus.mode_active); end
      if (i < 16) begin
        wait_tick(n);
        total++; if (n !== 9) begin bad++; $display("FAIL tick_period tick %0d: got %0d want 9", i, n); end
      end
    end
  endtask

  task automatic test_walk();
    int n;
    logic [3:0] seq [4];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (3) step();
    bus.mode_in = MODE_WALK; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    wait_tick(n);
    step();
    total++; if (bus.leds !== 4'b0001) begin bad++; $display("FAIL walk_start: got %b want 0001", bus.leds); end
    total++; if (bus.mode_active !== MODE_WALK) begin bad++; $display("FAIL walk_mode: got %0d want 1", bus.mode_active); end
    total++; if (bus.blink !== exp_blink) begin bad++; $display("FAIL walk_restart_blink: got %b want %b", bus.blink, exp_blink); end
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      step();
      if (i == 3) exp_blink = ~exp_blink;
      total++; if (bus.leds !== seq[i]) begin bad++; $display("FAIL walk_step %0d: got %b want %b", i, bus.leds, seq[i]); end
      total++; if (bus.blink !== exp_blink) begin bad++; $display("FAIL walk_blink %0d: got %b want %b", i, bus.blink, exp_blink); end
    end
    wait_tick(n);
    step();
    total++; if (bus.leds !== 4'b0010) begin bad++; $display("FAIL walk_pre_reload: got %b want 0010", bus.leds); end
    step();
    bus.mode_in = MODE_BOUNCE; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    step();
    bus.mode_in = MODE_WALK; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    wait_tick(n);
    step();
    total++; if (bus.mode_active !== MODE_WALK) begin bad++; $display("FAIL last_load_wins: got %0d want 1", bus.mode_active); end
    total++; if (bus.leds !== 4'b0001) begin bad++; $display("FAIL walk_reload_restart: got %b want 0001", bus.leds); end
    total++; if (bus.blink !== exp_blink) begin bad++; $display("FAIL walk_reload_blink: got %b want %b", bus.blink, exp_blink); end
  endtask

  task automatic test_bounce();
    int n;
    logic [3:0] seq [6];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    wait_tick(n);
    bus.mode_in = MODE_BOUNCE; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    total++; if (bus.mode_active !== MODE_BOUNCE) begin bad++; $display("FAIL bypass_mode: got %0d want 2", bus.mode_active); end
    total++; if (bus.leds !== 4'b0001) begin bad++; $display("FAIL bounce_start: got %b want 0001", bus.leds); end
    for (int i = 0; i < 6; i++) begin
      wait_tick(n);
      step();
      if (i == 5) exp_blink = ~exp_blink;
      total++; if (bus.leds !== seq[i]) begin bad++; $display("FAIL bounce_step %0d: got %b want %b", i, bus.leds, seq[i]); end
      total++; if (bus.blink !== exp_blink) begin bad++; $display("FAIL bounce_blink %0d: got %b want %b", i, bus.blink, exp_blink); end
    end
  endtask

  task automatic test_breathe();
    int n, hi, odd, want;
    repeat (4) step();
    bus.mode_in = MODE_BREATHE; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    wait_tick(n);
    step();
    total++; if (bus.mode_active !== MODE_BREATHE) begin bad++; $display("FAIL breathe_mode: got %0d want 3", bus.mode_active); end
    hi = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.leds !== 4'h0) hi++;
      if (c < 7) step();
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL duty0_dark: got %0d lit cycles want 0", hi); end
    for (int i = 1; i <= 14; i++) begin
      wait_tick(n);
      step();
      want = (i <= 7) ? i : 14 - i;
      if (i == 14) exp_blink = ~exp_blink;
      hi = 0; odd = 0;
      for (int c = 0; c < 8; c++) begin
        if (bus.leds === 4'hF) hi++;
        else if (bus.leds !== 4'h0) odd++;
        if (c < 7) step();
      end
      total++; if (hi !== want || odd !== 0) begin bad++; $display("FAIL breathe_duty tick %0d: got %0d/8 lit (%0d partial) want %0d/8", i, hi, odd, want); end
      total++; if (bus.blink !== exp_blink) begin bad++; $display("FAIL breathe_blink tick %0d: got %b want %b", i, bus.blink, exp_blink); end
    end
  endtask

  task automatic test_enable();
    int n, seen;
    wait_tick(n);
    bus.mode_in = MODE_BINARY; bus.mode_load = 1'b1;
    step();
    bus.mode_load = 1'b0;
    total++; if (bus.leds !== 4'h0 || bus.mode_active !== MODE_BINARY) begin bad++; $display("FAIL enable_setup: got leds=%h mode=%0d want 0/0", bus.leds, bus.mode_active); end
    wait_tick(n);
    step();
    repeat (4) step();
    bus.enable = 1'b0;
    seen = 0;
    for (int c = 0; c < 37; c++) begin
      step();
      if (bus.tick !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL pause_ticks: got %0d want 0", seen); end
    total++; if (bus.leds !== 4'h1) begin bad++; $display("FAIL pause_hold: got %h want 1", bus.leds); end
    bus.enable = 1'b1;
    wait_tick(n);
    total++; if (n !== 5) begin bad++; $display("FAIL resume_tick: got %0d cycles want 5", n); end
    step();
    total++; if (bus.leds !== 4'h2) begin bad++; $display("FAIL resume_step: got %h want 2", bus.leds); end
    wait_tick(n);
    total++; if (n !== 9) begin bad++; $display("FAIL resume_period: got %0d want 9", n); end
  endtask

  task automatic test_reset_midop();
    int n;
    step();
    total++; if (bus.leds !== 4'h3) begin bad++; $display("FAIL pre_reset_leds: got %h want 3", bus.leds); end
    repeat (3) step();
    bus.mode_in = MODE_BOUNCE; bus.mode_load = 1'b1; rst = 1'b1;
    step();
    bus.mode_load = 1'b0;
    exp_blink = 1'b0;
    total++; if (bus.mode_active !== MODE_BINARY) begin bad++; $display("FAIL midrst_mode: got %0d want 0", bus.mode_active); end
    total++; if (bus.leds !== 4'h0 || bus.blink !== 1'b0 || bus.tick !== 1'b0) begin bad++; $display("FAIL midrst_out: got leds=%h blink=%b tick=%b want 0/0/0", bus.leds, bus.blink, bus.tick); end
    step();
    rst = 1'b0;
    wait_tick(n);
    total++; if (n !== 9) begin bad++; $display("FAIL post_rst_tick: got %0d want 9", n); end
    step();
    total++; if (bus.mode_active !== MODE_BINARY) begin bad++; $display("FAIL pending_discarded: got %0d want 0", bus.mode_active); end
    total++; if (bus.leds !== 4'h1) begin bad++; $display("FAIL post_rst_step: got %h want 1", bus.leds); end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_walk();
    test_bounce();
    test_breathe();
    test_enable();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, wanted finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED pattern generator driven from the 50 MHz board clock; successor to the single-mode free-running LED counter.
- Contains an exact integer prescaler, a pattern step engine with four modes (binary count, walk, bounce, breathe), PWM brightness for breathe mode, and a heartbeat output that toggles once per pattern cycle.
- Sits at top level, feeding the LED bank and the heartbeat pin. Mode is loaded by a pulse and applied on a tick boundary.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 8, pattern step rate in Hz. DIV = CLK_HZ/TICK_HZ, integer division, must be ≥2.
- NUM_LEDS, 6, LED channel count; range 2..16.
- PWM_BITS, 8, breathe duty and PWM counter width.

Ports:
- clk50 in 1: sole clock, rising edge.
- rst in 1: synchronous, active-high reset.
- enable in 1: 1 = prescaler runs; 0 = prescaler, pattern and PWM counter all freeze.
- mode_in in 2: requested mode. 0 BINARY, 1 WALK, 2 BOUNCE, 3 BREATHE.
- mode_load in 1: single-cycle request to adopt mode_in.
- mode_active out 2: currently applied mode.
- tick out 1: one-cycle strobe at step rate.
- leds out NUM_LEDS: LED drive, active-high.
- blink out 1: heartbeat; toggles on every pattern wrap.

Behaviour:
- Reset values (held while rst=1): prescaler 0, tick 0, mode_active BINARY, pattern 0, leds 0, blink 0, pending flag 0, PWM counter 0, duty 0, direction up.
- Prescaler:
  - Counts 0..DIV-1 while enable=1.
  - tick=1 for exactly the cycle in which the count equals DIV-1, then the count wraps to 0.
  - Tick period is exactly DIV cycles.
- Pattern updates in the tick cycle. leds reflect the new pattern on the following cycle (registered output, latency 1 from tick).
- Mode load:
  - mode_load=1 latches mode_in into pending and sets the pending flag.
  - Multiple loads before a tick: the last one wins.
  - On a tick with the pending flag set: mode_active takes the pending value, the pattern restarts at that mode's initial state, no step occurs on that tick, and the pending flag clears.
  - mode_load asserted in the tick cycle itself applies on that same tick (bypass).
  - Reloading the current mode also restarts its pattern.
- BINARY: pattern is an unsigned counter over NUM_LEDS bits, starting at 0, +1 per tick. 2^NUM_LEDS-1 → 0 is a wrap. leds = pattern.
- WALK: one-hot, starts at bit0, rotates left one position per tick. Bit NUM_LEDS-1 → bit0 is a wrap.
- BOUNCE: one-hot, starts at bit0 with direction up.
  - Shifts left while up; at bit NUM_LEDS-1 the direction flips and the next step shifts right.
  - At bit0 while moving down the direction flips to up. Arriving at bit0 is a wrap.
  - Endpoints are shown for one tick only (period 2·NUM_LEDS-2 ticks).
- BREATHE: duty starts at 0 and changes by 1 per tick: up to 2^PWM_BITS-1, then down to 0.
  - Reaching 0 on the way down is a wrap. Period 2·(2^PWM_BITS-1) ticks.
  - PWM counter is free-running PWM_BITS wide, +1 per cycle while enabled.
  - All leds = (pwm_cnt < duty). Duty 0 means always off; max duty means off for 1 cycle per PWM period.
- blink toggles in the same cycle its wrap step is applied (becomes visible the next cycle, like leds). A mode restart is not a wrap.
- enable=0 mid-period holds all state. Resuming continues from the held prescaler count, with no extra or lost tick.
- rst asserted mid-operation returns everything to reset values on the next edge and discards any pending mode.

Decomposition:
- Package led_pattern_pkg holds:
  - mode encoding constants MODE_BINARY=0, MODE_WALK=1, MODE_BOUNCE=2, MODE_BREATHE=3;
  - localparam function for DIV and the prescaler width, clog2(DIV).
- One sub-module, tick_prescaler (params DIV; ports clk50, rst, enable, tick), instantiated once. Step engine and PWM stay in led_pattern_gen.

Test Plan:
- Reset/prescaler (CLK_HZ=40, TICK_HZ=4, so DIV=10; NUM_LEDS=4): release rst → tick first at cycle 10, then every 10 cycles; leds=0, blink=0 until the first tick.
- BINARY wrap: 16 ticks → leds 1,2,…,15,0; blink 0→1 in the cycle after the 16th tick; mode_active stays 0.
- WALK via load: pulse mode_load with mode_in=1 mid-period → next tick sets leds=0001 (no step), then 0010, 0100, 1000, 0001 with blink toggling on the last step; two loads (2 then 1) before a tick → WALK applied.
- BOUNCE endpoints: mode 2 → leds 0001,0010,0100,1000,0100,0010,0001; blink toggles only at the final 0001.
- BREATHE PWM (PWM_BITS=3): at duty 3 the leds duty cycle is exactly 3 of 8 cycles; duty sequence 0..7..0 with a blink toggle at the return to 0; duty 0 keeps leds all zero.
- enable/reset mid-op: enable=0 for 37 cycles at prescaler count 4 → next tick is delayed by exactly 37 cycles; rst in the cycle of a mode_load → mode_active=0, pending discarded, leds=0.
